// File: rtl/id_stage_pkg.sv
// Shared types, opcode constants and decode helpers for the registered ID stage.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package id_stage_pkg;

  // Bundle data fields are fixed at RV32 width; the stage parameter defaults to this.
  localparam int ID_DW = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } aluop_t;

  typedef enum logic [3:0] {
    CFU_NONE, CFU_BEQ, CFU_BNE, CFU_BLT, CFU_BGE, CFU_BLTU, CFU_BGEU, CFU_JAL, CFU_JALR
  } cfuop_t;

  typedef enum logic [3:0] {
    LSU_NONE, LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW
  } lsuop_t;

  typedef enum logic       {OPA_RS1, OPA_PC}          opasel_t;
  typedef enum logic       {OPB_RS2, OPB_IMM}         opbsel_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4}   wbsel_t;

  // Control unit output; illegal flags an opcode/funct3 the unit does not know.
  typedef struct packed {
    aluop_t  aluop;
    cfuop_t  cfuop;
    lsuop_t  lsuop;
    logic    rf_en;
    logic    dm_en;
    opasel_t opr_a_sel;
    opbsel_t opr_b_sel;
    wbsel_t  wb_sel;
    logic    illegal;
  } ctrl_t;

  typedef struct packed {
    logic [ID_DW-1:0] opr_a;
    logic [ID_DW-1:0] opr_b;
    logic [ID_DW-1:0] imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [ID_DW-1:0] pc;
    logic [ID_DW-1:0] pc4;
    aluop_t           aluop;
    cfuop_t           cfuop;
    lsuop_t           lsuop;
    logic             rf_en;
    logic             dm_en;
    opasel_t          opr_a_sel;
    opbsel_t          opr_b_sel;
    wbsel_t           wb_sel;
  } id_stage_out_t;

  // Sign-extended immediate for the instruction's format; R type and unknown give 0.
  function automatic logic [ID_DW-1:0] gen_imm_f(input logic [31:0] inst);
    logic [ID_DW-1:0] imm;
    imm = '0;
    case (inst[6:0])
      OPC_LOAD, OPC_JALR, OPC_OPIMM: imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm = {inst[31:12], 12'b0};
      OPC_JAL:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:    imm = '0;
    endcase
    return imm;
  endfunction

  function automatic logic uses_rs1_f(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE) || (opc == OPC_BRANCH) ||
           (opc == OPC_JALR) || (opc == OPC_OP)    || (opc == OPC_OPIMM);
  endfunction

  function automatic logic uses_rs2_f(input logic [6:0] opc);
    return (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_OP);
  endfunction

  function automatic logic uses_rd_f(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_JAL)   || (opc == OPC_JALR) || (opc == OPC_LUI) ||
           (opc == OPC_AUIPC) || (opc == OPC_OP)   || (opc == OPC_OPIMM);
  endfunction

  function automatic logic is_load_f(input lsuop_t op);
    return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
           (op == LSU_LBU) || (op == LSU_LHU);
  endfunction

endpackage

// File: rtl/ctrl_unit.sv
// Combinational control decode: opcode/funct3/funct7[5] to ALU, CFU, LSU and mux selects.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the presented instruction.
module ctrl_unit
  import id_stage_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output ctrl_t      ctrl
);

  // funct3 to ALU op; SUB only exists for register-register, SRA for both.
  function automatic aluop_t alu_f3_f(input logic [2:0] f3, input logic alt, input logic reg_reg);
    aluop_t op;
    case (f3)
      3'b000:  op = (alt && reg_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Main decode table; anything not matched below is flagged illegal.
  always_comb begin
    ctrl = '0;
    case (opcode)
      OPC_OP: begin
        ctrl.aluop = alu_f3_f(funct3, funct7_5, 1'b1);
        ctrl.rf_en = 1'b1;
      end
      OPC_OPIMM: begin
        ctrl.aluop     = alu_f3_f(funct3, funct7_5, 1'b0);
        ctrl.rf_en     = 1'b1;
        ctrl.opr_b_sel = OPB_IMM;
      end
      OPC_LOAD: begin
        ctrl.rf_en     = 1'b1;
        ctrl.opr_b_sel = OPB_IMM;
        ctrl.wb_sel    = WB_MEM;
        case (funct3)
          3'b000:  ctrl.lsuop = LSU_LB;
          3'b001:  ctrl.lsuop = LSU_LH;
          3'b010:  ctrl.lsuop = LSU_LW;
          3'b100:  ctrl.lsuop = LSU_LBU;
          3'b101:  ctrl.lsuop = LSU_LHU;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ctrl.dm_en     = 1'b1;
        ctrl.opr_b_sel = OPB_IMM;
        case (funct3)
          3'b000:  ctrl.lsuop = LSU_SB;
          3'b001:  ctrl.lsuop = LSU_SH;
          3'b010:  ctrl.lsuop = LSU_SW;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        // ALU forms the target; the CFU does the compare on the raw operands.
        ctrl.opr_a_sel = OPA_PC;
        ctrl.opr_b_sel = OPB_IMM;
        case (funct3)
          3'b000:  ctrl.cfuop = CFU_BEQ;
          3'b001:  ctrl.cfuop = CFU_BNE;
          3'b100:  ctrl.cfuop = CFU_BLT;
          3'b101:  ctrl.cfuop = CFU_BGE;
          3'b110:  ctrl.cfuop = CFU_BLTU;
          3'b111:  ctrl.cfuop = CFU_BGEU;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        ctrl.cfuop     = CFU_JAL;
        ctrl.rf_en     = 1'b1;
        ctrl.opr_a_sel = OPA_PC;
        ctrl.opr_b_sel = OPB_IMM;
        ctrl.wb_sel    = WB_PC4;
      end
      OPC_JALR: begin
        ctrl.cfuop     = CFU_JALR;
        ctrl.rf_en     = 1'b1;
        ctrl.opr_b_sel = OPB_IMM;
        ctrl.wb_sel    = WB_PC4;
        ctrl.illegal   = (funct3 != 3'b000);
      end
      OPC_LUI: begin
        ctrl.aluop     = ALU_PASSB;
        ctrl.rf_en     = 1'b1;
        ctrl.opr_b_sel = OPB_IMM;
      end
      OPC_AUIPC: begin
        ctrl.rf_en     = 1'b1;
        ctrl.opr_a_sel = OPA_PC;
        ctrl.opr_b_sel = OPB_IMM;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rf_wt.sv
// Register file, x0 hardwired to zero, two async read ports with write-through bypass.
// Latency: reads 0 cycles; a write lands at the clock edge but is visible in the same cycle.
// Backpressure: none; writes outside the implemented register range are dropped.
module rf_wt #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [4:0]            raddr1,
  input  logic [4:0]            raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  localparam int AW   = $clog2(NUM_REGS);
  localparam bit FULL = (NUM_REGS == 32);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wr_ok;

  // With 16 registers, index bit 4 set names a register that does not exist.
  function automatic logic in_range_f(input logic [4:0] a);
    return FULL | ~a[4];
  endfunction

  assign wr_ok = we && (waddr != 5'd0) && in_range_f(waddr);

  // Storage update; reset clears every register.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

  // Read port 1: zero for x0 and non-existent registers, bypass on same-cycle write.
  always_comb begin
    rdata1 = '0;
    if (raddr1 != 5'd0 && in_range_f(raddr1))
      rdata1 = (wr_ok && waddr == raddr1) ? wdata : regs[raddr1[AW-1:0]];
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rdata2 = '0;
    if (raddr2 != 5'd0 && in_range_f(raddr2))
      rdata2 = (wr_ok && waddr == raddr2) ? wdata : regs[raddr2[AW-1:0]];
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage: regfile read, control decode, immediates, load-use interlock.
// Latency: 1 cycle from IF accept to ex_valid_out; one instruction per cycle without hazards.
// Backpressure: valid/ready both sides; bundle frozen while EX stalls, flush overrides all.
module id_stage_pipe
  import id_stage_pkg::*;
#(
  parameter int DATA_WIDTH = ID_DW,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  if_valid_in,
  output logic                  if_ready_out,
  input  logic [31:0]           inst_in,
  input  logic [DATA_WIDTH-1:0] pc_in,
  input  logic [DATA_WIDTH-1:0] pc4_in,
  input  logic                  flush_in,
  input  logic                  wb_rf_en_in,
  input  logic [4:0]            wb_rd_in,
  input  logic [DATA_WIDTH-1:0] wb_data_in,
  output logic                  ex_valid_out,
  input  logic                  ex_ready_in,
  output id_stage_out_t         ex_out,
  output logic                  illegal_out
);

  localparam bit RV32E = (NUM_REGS == 16);

  logic [6:0]            opcode;
  logic [4:0]            rs1, rs2, rd;
  logic [DATA_WIDTH-1:0] rs1_dat, rs2_dat;
  ctrl_t                 ctrl;
  logic                  reg_oob;
  logic                  dec_illegal;
  id_stage_out_t         dec;
  logic                  ld_pending;
  logic                  hazard;
  logic                  accept;

  assign opcode = inst_in[6:0];
  assign rd     = inst_in[11:7];
  assign rs1    = inst_in[19:15];
  assign rs2    = inst_in[24:20];

  ctrl_unit u_ctrl (
    .opcode   (opcode),
    .funct3   (inst_in[14:12]),
    .funct7_5 (inst_in[30]),
    .ctrl     (ctrl)
  );

  rf_wt #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rf (
    .clk    (clk),
    .arst_n (arst_n),
    .we     (wb_rf_en_in),
    .waddr  (wb_rd_in),
    .wdata  (wb_data_in),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_dat),
    .rdata2 (rs2_dat)
  );

  // Only fields that the format actually uses as registers are range-checked, so
  // immediate bits sitting in the rs1/rs2 positions (LUI, JAL, ...) are not misflagged.
  assign reg_oob = RV32E && ((uses_rs1_f(opcode) && rs1[4]) ||
                             (uses_rs2_f(opcode) && rs2[4]) ||
                             (uses_rd_f(opcode)  && rd[4]));

  assign dec_illegal = ctrl.illegal | reg_oob;

  // Assemble the next bundle; illegal instructions never write the RF or memory.
  always_comb begin
    dec           = '0;
    dec.opr_a     = rs1_dat;
    dec.opr_b     = rs2_dat;
    dec.imm       = gen_imm_f(inst_in);
    dec.rs1       = rs1;
    dec.rs2       = rs2;
    dec.rd        = rd;
    dec.pc        = pc_in;
    dec.pc4       = pc4_in;
    dec.aluop     = ctrl.aluop;
    dec.cfuop     = ctrl.cfuop;
    dec.lsuop     = ctrl.lsuop;
    dec.rf_en     = ctrl.rf_en & ~dec_illegal;
    dec.dm_en     = ctrl.dm_en & ~dec_illegal;
    dec.opr_a_sel = ctrl.opr_a_sel;
    dec.opr_b_sel = ctrl.opr_b_sel;
    dec.wb_sel    = ctrl.wb_sel;
  end

  // A load sitting in the output register cannot forward its data in time for a consumer.
  assign ld_pending = ex_valid_out && is_load_f(ex_out.lsuop) && (ex_out.rd != 5'd0);
  assign hazard     = ld_pending && if_valid_in &&
                      ((uses_rs1_f(opcode) && rs1 == ex_out.rd) ||
                       (uses_rs2_f(opcode) && rs2 == ex_out.rd));

  assign if_ready_out = flush_in | ((~ex_valid_out | ex_ready_in) & ~hazard);
  assign accept       = if_valid_in & if_ready_out;

  // Output register: flush, bubble, hold, load new, drain -- in that priority.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      ex_valid_out <= 1'b0;
      ex_out       <= '0;
      illegal_out  <= 1'b0;
    end else if (flush_in) begin
      ex_valid_out <= 1'b0;
      illegal_out  <= 1'b0;
    end else if (hazard && ex_ready_in) begin
      ex_valid_out <= 1'b0;
      illegal_out  <= 1'b0;
    end else if (ex_valid_out && !ex_ready_in) begin
      // Hold: operands stay as captured; EX forwarding supplies any newer value.
      ex_valid_out <= 1'b1;
    end else if (accept) begin
      ex_valid_out <= 1'b1;
      ex_out       <= dec;
      illegal_out  <= dec_illegal;
    end else if (ex_valid_out && ex_ready_in) begin
      ex_valid_out <= 1'b0;
      illegal_out  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: scoreboarded bundles for the RV32I build plus
// direct checks on an RV32E build for out-of-range register handling.
module tb_id_stage_pipe;
  import id_stage_pkg::*;

  logic          clk;
  logic          arst_n;
  logic          if_valid_in, if_ready_out, flush_in, wb_rf_en_in, ex_valid_out, ex_ready_in, illegal_out;
  logic [31:0]   inst_in, pc_in, pc4_in, wb_data_in;
  logic [4:0]    wb_rd_in;
  id_stage_out_t ex_out;

  logic          e_if_valid_in, e_if_ready_out, e_flush_in, e_wb_rf_en_in, e_ex_valid_out, e_ex_ready_in, e_illegal_out;
  logic [31:0]   e_inst_in, e_pc_in, e_pc4_in, e_wb_data_in;
  logic [4:0]    e_wb_rd_in;
  id_stage_out_t e_ex_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rd;
    logic [31:0] imm;
    logic [31:0] opr_a;
    logic        rf_en;
    logic        dm_en;
    logic        ill;
  } exp_t;

  exp_t          sb[$];
  id_stage_out_t snap;

  id_stage_pipe #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .clk(clk), .arst_n(arst_n), .if_valid_in(if_valid_in), .if_ready_out(if_ready_out),
    .inst_in(inst_in), .pc_in(pc_in), .pc4_in(pc4_in), .flush_in(flush_in),
    .wb_rf_en_in(wb_rf_en_in), .wb_rd_in(wb_rd_in), .wb_data_in(wb_data_in),
    .ex_valid_out(ex_valid_out), .ex_ready_in(ex_ready_in), .ex_out(ex_out), .illegal_out(illegal_out)
  );

  id_stage_pipe #(.DATA_WIDTH(32), .NUM_REGS(16)) dut_e (
    .clk(clk), .arst_n(arst_n), .if_valid_in(e_if_valid_in), .if_ready_out(e_if_ready_out),
    .inst_in(e_inst_in), .pc_in(e_pc_in), .pc4_in(e_pc4_in), .flush_in(e_flush_in),
    .wb_rf_en_in(e_wb_rf_en_in), .wb_rd_in(e_wb_rd_in), .wb_data_in(e_wb_data_in),
    .ex_valid_out(e_ex_valid_out), .ex_ready_in(e_ex_ready_in), .ex_out(e_ex_out), .illegal_out(e_illegal_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    if_valid_in = 1'b1;
    inst_in     = inst;
    pc_in       = pc;
    pc4_in      = pc + 32'd4;
  endtask

  task automatic e_present(input logic [31:0] inst, input logic [31:0] pc);
    e_if_valid_in = 1'b1;
    e_inst_in     = inst;
    e_pc_in       = pc;
    e_pc4_in      = pc + 32'd4;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_rf_en_in = 1'b1;
    wb_rd_in    = r;
    wb_data_in  = d;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] rd, input logic [31:0] imm,
                      input logic [31:0] opa, input logic rf, input logic dm, input logic ill);
    exp_t x;
    x.pc = pc; x.rd = rd; x.imm = imm; x.opr_a = opa; x.rf_en = rf; x.dm_en = dm; x.ill = ill;
    sb.push_back(x);
  endtask

  // Scoreboard: every bundle EX takes must be the next expected one.
  always @(negedge clk) begin
    exp_t x;
    if (arst_n && ex_valid_out && ex_ready_in) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow observed bundle pc %0h required no bundle", ex_out.pc);
      end
      if (sb.size() != 0) begin
        x = sb.pop_front();
        chk("sb_pc",      ex_out.pc, x.pc);
        chk("sb_rd",      32'(ex_out.rd), x.rd);
        chk("sb_imm",     ex_out.imm, x.imm);
        chk("sb_opr_a",   ex_out.opr_a, x.opr_a);
        chk("sb_rf_en",   32'(ex_out.rf_en), 32'(x.rf_en));
        chk("sb_dm_en",   32'(ex_out.dm_en), 32'(x.dm_en));
        chk("sb_illegal", 32'(illegal_out), 32'(x.ill));
      end
    end
  end

  initial begin
    arst_n = 1'b0; if_valid_in = 1'b0; inst_in = '0; pc_in = '0; pc4_in = '0; flush_in = 1'b0;
    wb_rf_en_in = 1'b0; wb_rd_in = '0; wb_data_in = '0; ex_ready_in = 1'b1;
    e_if_valid_in = 1'b0; e_inst_in = '0; e_pc_in = '0; e_pc4_in = '0; e_flush_in = 1'b0;
    e_wb_rf_en_in = 1'b0; e_wb_rd_in = '0; e_wb_data_in = '0; e_ex_ready_in = 1'b1;

    cyc(); cyc();
    chk("rst_valid", 32'(ex_valid_out), 32'd0);
    checks++;
    assert (ex_out === '0) else begin
      errors++;
      $error("FAIL rst_bundle observed %h required 0", ex_out);
    end
    chk("rst_illegal", 32'(illegal_out), 32'd0);
    arst_n = 1'b1;
    #1;
    chk("rst_if_ready", 32'(if_ready_out), 32'd1);

    // addi x1,x0,5
    present(32'h00500093, 32'h100);
    push(32'h100, 32'd1, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0);
    #1 chk("addi_if_ready", 32'(if_ready_out), 32'd1);
    cyc();
    if_valid_in = 1'b0;
    chk("addi_valid", 32'(ex_valid_out), 32'd1);
    wb(5'd1, 32'd5);
    cyc();
    wb_rf_en_in = 1'b0;

    // lw x2,0(x1) then add x3,x2,x2: one bubble
    present(32'h0000A103, 32'h104);
    push(32'h104, 32'd2, 32'd0, 32'd5, 1'b1, 1'b0, 1'b0);
    cyc();
    present(32'h002101B3, 32'h108);
    #1 chk("lu_if_ready", 32'(if_ready_out), 32'd0);
    cyc();
    chk("lu_bubble", 32'(ex_valid_out), 32'd0);
    chk("lu_if_ready_after", 32'(if_ready_out), 32'd1);
    wb(5'd2, 32'h77);
    push(32'h108, 32'd3, 32'd0, 32'h77, 1'b1, 1'b0, 1'b0);
    cyc();
    wb_rf_en_in = 1'b0;
    chk("lu_add_issued", 32'(ex_valid_out), 32'd1);

    // add x6,x5,x0 with WB x5 in the same cycle
    present(32'h00028333, 32'h10C);
    wb(5'd5, 32'hDEADBEEF);
    push(32'h10C, 32'd6, 32'd0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    cyc();
    wb_rf_en_in = 1'b0;
    chk("wt_opr_a", ex_out.opr_a, 32'hDEADBEEF);

    // EX stall for 3 cycles with WB to the held bundle's rs1
    ex_ready_in = 1'b0;
    present(32'hFE20AE23, 32'h110);
    snap = ex_out;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_if_ready", 32'(if_ready_out), 32'd0);
      wb(5'd5, 32'h1234);
      cyc();
      checks++;
      assert (ex_out === snap) else begin
        errors++;
        $error("FAIL stall_hold observed %h required %h", ex_out, snap);
      end
      chk("stall_valid", 32'(ex_valid_out), 32'd1);
    end
    wb_rf_en_in = 1'b0;
    ex_ready_in = 1'b1;
    push(32'h110, 32'd28, 32'hFFFFFFFC, 32'd5, 1'b0, 1'b1, 1'b0);
    cyc();

    // lw x4 then a dependent add presented together with flush
    present(32'h0000A203, 32'h114);
    push(32'h114, 32'd4, 32'd0, 32'd5, 1'b1, 1'b0, 1'b0);
    cyc();
    present(32'h004204B3, 32'h118);
    flush_in = 1'b1;
    #1 chk("flush_if_ready", 32'(if_ready_out), 32'd1);
    cyc();
    flush_in = 1'b0;
    chk("flush_valid", 32'(ex_valid_out), 32'd0);
    present(32'h123453B7, 32'h200);
    #1 chk("post_flush_ready", 32'(if_ready_out), 32'd1);
    push(32'h200, 32'd7, 32'h12345000, 32'd0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("post_flush_valid", 32'(ex_valid_out), 32'd1);

    // unknown opcode
    present(32'hFFFFFFFF, 32'h204);
    push(32'h204, 32'd31, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cyc();
    if_valid_in = 1'b0;
    chk("illegal_set", 32'(illegal_out), 32'd1);
    cyc();
    chk("illegal_idle", 32'(illegal_out), 32'd0);
    chk("idle_valid", 32'(ex_valid_out), 32'd0);

    // RV32E build: x1 then an aliasing write to x17
    e_wb_rf_en_in = 1'b1; e_wb_rd_in = 5'd1; e_wb_data_in = 32'h11;
    cyc();
    e_wb_rd_in = 5'd17; e_wb_data_in = 32'h999;
    cyc();
    e_wb_rf_en_in = 1'b0;
    e_present(32'h002088B3, 32'h300);   // add x17,x1,x2
    cyc();
    chk("e_valid", 32'(e_ex_valid_out), 32'd1);
    chk("e_rd17_illegal", 32'(e_illegal_out), 32'd1);
    chk("e_rd17_rf_en", 32'(e_ex_out.rf_en), 32'd0);
    chk("e_x1_kept", e_ex_out.opr_a, 32'h11);
    e_present(32'h000880B3, 32'h304);   // add x1,x17,x0
    cyc();
    chk("e_rs17_illegal", 32'(e_illegal_out), 32'd1);
    chk("e_rs17_zero", e_ex_out.opr_a, 32'd0);
    e_present(32'h00500093, 32'h308);   // addi x1,x0,5
    cyc();
    e_if_valid_in = 1'b0;
    chk("e_legal", 32'(e_illegal_out), 32'd0);
    chk("e_legal_rf_en", 32'(e_ex_out.rf_en), 32'd1);
    chk("e_legal_imm", e_ex_out.imm, 32'd5);

    cyc(); cyc();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
